// File: rtl/ft245_burst.sv
// FT245 synchronous-FIFO bridge: moves words between a valid/ready user port and the
// FT245 bus in bounded bursts, alternating direction when both sides have work.
module ft245_burst #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              _txe,
  input  logic              _rxf,
  output logic              _rd,
  output logic              _wr,
  output logic              _oe,
  inout  wire  [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              rx_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic [CNT_W-1:0]  tx_total,
  output logic [CNT_W-1:0]  rx_total
);

  // state  | meaning
  // IDLE   | arbitrate between pending TX and RX work
  // TX     | we drive the bus, one word per edge while the FT245 has room
  // RX_OE  | FT245 output enabled, bus turning toward us, no read yet
  // RX     | one word per edge while the FT245 has data
  // RX_END | bus released before anyone may drive it again
  typedef enum logic [2:0] {S_IDLE, S_TX, S_RX_OE, S_RX, S_RX_END} state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [7:0] burst_q;
  logic       last_rx_q;
  logic       tx_req, rx_req, tx_xfer, rx_xfer, burst_done, drive;

  assign tx_req     = tx_valid & ~_txe;
  assign rx_req     = rx_en & ~_rxf;
  assign tx_xfer    = (state_q == S_TX) & tx_req;
  assign rx_xfer    = (state_q == S_RX) & rx_req;
  assign burst_done = (burst_q == BURST_LAST);

  assign data = drive ? tx_data : {DATA_W{1'bz}};

  // Strobes are held off while reset is low so the FT245 never sees a word the
  // counters will not record.
  always_comb begin
    state_d  = state_q;
    drive    = 1'b0;
    tx_ready = 1'b0;
    _wr      = 1'b1;
    _rd      = 1'b1;
    _oe      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (tx_req && rx_req) state_d = last_rx_q ? S_TX : S_RX_OE;
        else if (tx_req)      state_d = S_TX;
        else if (rx_req)      state_d = S_RX_OE;
      end
      S_TX: begin
        drive    = _reset;
        tx_ready = ~_txe & _reset;
        _wr      = ~(tx_valid & _reset);
        if (!tx_req || burst_done) state_d = S_IDLE;
      end
      S_RX_OE: begin
        _oe     = 1'b0;
        state_d = S_RX;
      end
      S_RX: begin
        _oe = 1'b0;
        _rd = ~(rx_en & _reset);
        if (!rx_req || burst_done) state_d = S_RX_END;
      end
      S_RX_END: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!_reset) begin
      state_q   <= S_IDLE;
      burst_q   <= '0;
      last_rx_q <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_total  <= '0;
      rx_total  <= '0;
    end else begin
      state_q  <= state_d;
      rx_valid <= rx_xfer;
      if (rx_xfer) begin
        rx_data  <= data;
        rx_total <= rx_total + CNT_W'(1);
      end
      if (tx_xfer) tx_total <= tx_total + CNT_W'(1);
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        burst_q   <= '0;
        last_rx_q <= (state_d == S_RX_OE);
      end else if (tx_xfer || rx_xfer) begin
        burst_q <= burst_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ft245_burst.sv
// Bench for ft245_burst: an FT245 bus model plus word-stream scoreboard; burst shapes
// are recovered from a per-cycle transfer trace.
module tb_ft245_burst;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int CW = 4;

  logic          clk, reset_b, txe_b, rxf_b, tx_valid, rx_en;
  logic [DW-1:0] tx_data, ft_word;
  logic          rd_b, wr_b, oe_b, tx_ready, rx_valid;
  logic [DW-1:0] rx_data;
  logic [CW-1:0] tx_total, rx_total;
  wire  [DW-1:0] data;

  // FT245 side drives the bus whenever its output enable is asserted
  assign data = oe_b ? {DW{1'bz}} : ft_word;

  ft245_burst #(.DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
    .clk(clk), ._reset(reset_b), ._txe(txe_b), ._rxf(rxf_b),
    ._rd(rd_b), ._wr(wr_b), ._oe(oe_b), .data(data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_total(tx_total), .rx_total(rx_total)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int            n_chk, n_bad;
  logic [DW-1:0] tx_word, rx_exp;
  int            tx_cnt, rx_cnt, rx_avail, cyc;
  int            run_len, run_dir;
  logic          prev_oe_b;
  int            oe_low_n, rd_low_n, vx_n, first_oe, first_rd;
  int            trace_q[$];
  int            r_dir[$], r_len[$], r_gap[$];
  bit            pulsed;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe strobes before the edge, update the model after it.
  task automatic cycle();
    logic tx_x, rx_x, in_rst;
    int   code;
    #1;
    in_rst = !reset_b;
    tx_x   = 1'b0;
    rx_x   = 1'b0;
    if (!in_rst) begin
      if (!tx_valid) check("wr_without_valid", wr_b, 1);
      if (!rx_en)    check("rd_without_en", rd_b, 1);
      if (!wr_b)     check("wr_while_oe", oe_b, 1);
      if (!rd_b)     check("rd_without_oe_lead", prev_oe_b, 0);
      tx_x = !wr_b && !txe_b;
      rx_x = !rd_b && !rxf_b;
      check("tx_handshake", tx_valid && tx_ready, tx_x);
      if (tx_x) check("tx_byte", data, tx_word);
      if (!oe_b) begin
        oe_low_n++;
        if (first_oe < 0) first_oe = cyc;
      end
      if (!rd_b) begin
        rd_low_n++;
        if (first_rd < 0) first_rd = cyc;
      end
    end
    prev_oe_b = oe_b;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (in_rst) begin
      tx_cnt    = 0;
      rx_cnt    = 0;
      rx_exp    = '0;
      run_len   = 0;
      prev_oe_b = 1'b1;
      trace_q.push_back(0);
      check("rst_wr", wr_b, 1);
      check("rst_rd", rd_b, 1);
      check("rst_oe", oe_b, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_tx_total", tx_total, 0);
      check("rst_rx_total", rx_total, 0);
    end else begin
      if (tx_x) begin
        tx_cnt++;
        tx_word = DW'($urandom);
        tx_data = tx_word;
      end
      if (rx_x) begin
        rx_cnt++;
        rx_exp  = ft_word;
        ft_word = DW'($urandom);
        if (rx_avail > 0) rx_avail--;
      end
      check("rx_valid", rx_valid, rx_x);
      if (rx_x) check("rx_data", rx_data, rx_exp);
      if (rx_valid) vx_n++;
      check("tx_total", tx_total, tx_cnt % (1 << CW));
      check("rx_total", rx_total, rx_cnt % (1 << CW));
      code = tx_x ? 1 : (rx_x ? 2 : 0);
      trace_q.push_back(code);
      if (code != 0) begin
        if (run_len > 0 && run_dir == code) run_len++;
        else run_len = 1;
        run_dir = code;
        check("burst_over_max", run_len > MB, 0);
      end else begin
        run_len = 0;
      end
    end
  endtask

  // Collapse the trace into bursts: direction, length, idle cycles before it.
  task automatic summarize();
    int gap;
    r_dir.delete();
    r_len.delete();
    r_gap.delete();
    gap = 0;
    foreach (trace_q[i]) begin
      if (trace_q[i] == 0) begin
        gap++;
      end else if (i > 0 && trace_q[i-1] == trace_q[i]) begin
        r_len[r_len.size()-1] = r_len[r_len.size()-1] + 1;
      end else begin
        r_dir.push_back(trace_q[i]);
        r_len.push_back(1);
        r_gap.push_back(gap);
        gap = 0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_b = 1'b0;
    repeat (n) cycle();
    reset_b = 1'b1;
  endtask

  task automatic clear_stats();
    trace_q.delete();
    oe_low_n = 0;
    rd_low_n = 0;
    vx_n     = 0;
    first_oe = -1;
    first_rd = -1;
  endtask

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0;
    tx_cnt = 0; rx_cnt = 0; rx_avail = 0; run_len = 0; run_dir = 0;
    prev_oe_b = 1'b1;
    tx_word = DW'($urandom);
    tx_data = tx_word;
    ft_word = DW'($urandom);
    rx_exp = '0;
    txe_b = 1'b1; rxf_b = 1'b1; tx_valid = 1'b0; rx_en = 1'b0;
    clear_stats();
    do_reset(2);

    // 40 words with the FT245 always ready: bursts of 16, 16, 8
    clear_stats();
    txe_b = 1'b0;
    for (int c = 0; c < 80 && tx_cnt < 40; c++) begin
      tx_valid = (tx_cnt < 40);
      cycle();
    end
    tx_valid = 1'b0;
    repeat (3) cycle();
    check("t36_words", tx_cnt, 40);
    check("t36_tx_total", tx_total, 40 % (1 << CW));
    summarize();
    check("t36_nbursts", r_dir.size(), 3);
    if (r_len.size() >= 3) begin
      check("t36_len0", r_len[0], 16);
      check("t36_len1", r_len[1], 16);
      check("t36_len2", r_len[2], 8);
      check("t36_gap1", r_gap[1], 1);
      check("t36_gap2", r_gap[2], 1);
    end

    // 5 words from the PC, then _rxf rises
    clear_stats();
    txe_b = 1'b1; rx_en = 1'b1; rx_avail = 5;
    for (int c = 0; c < 20; c++) begin
      rxf_b = (rx_avail == 0);
      cycle();
    end
    check("t37_pulses", vx_n, 5);
    check("t37_rx_total", rx_total, 5);
    check("t37_oe_lead", first_rd - first_oe, 1);
    check("t37_oe_cycles", oe_low_n, 7);
    check("t37_rd_cycles", rd_low_n, 6);

    // both directions pending from reset: RX first, then alternate
    tx_valid = 1'b1; txe_b = 1'b0; rx_en = 1'b1; rxf_b = 1'b0; rx_avail = 1000;
    do_reset(2);
    clear_stats();
    repeat (100) cycle();
    summarize();
    check("t38_nbursts_min", r_dir.size() >= 4, 1);
    if (r_dir.size() >= 4) begin
      for (int b = 0; b < 4; b++) begin
        check("t38_dir", r_dir[b], (b % 2 == 0) ? 2 : 1);
        check("t38_len", r_len[b], 16);
      end
    end

    // _txe pulses high for one cycle just before word 7
    tx_valid = 1'b1; txe_b = 1'b0; rx_en = 1'b0; rxf_b = 1'b1;
    do_reset(1);
    clear_stats();
    pulsed = 1'b0;
    for (int c = 0; c < 80 && tx_cnt < 20; c++) begin
      txe_b = (tx_cnt == 6 && !pulsed);
      if (txe_b) pulsed = 1'b1;
      cycle();
    end
    tx_valid = 1'b0; txe_b = 1'b0;
    repeat (3) cycle();
    check("t39_words", tx_cnt, 20);
    summarize();
    check("t39_nbursts", r_dir.size(), 2);
    if (r_len.size() >= 2) begin
      check("t39_len0", r_len[0], 6);
      check("t39_len1", r_len[1], 14);
      check("t39_gap1", r_gap[1], 2);
    end

    // 18 reads wrap a 4-bit counter to 2
    txe_b = 1'b1; rx_en = 1'b1; rx_avail = 18;
    do_reset(1);
    for (int c = 0; c < 60; c++) begin
      rxf_b = (rx_avail == 0);
      cycle();
    end
    check("t40_reads", rx_cnt, 18);
    check("t40_wrap", rx_total, 2);

    // reset in the middle of an RX burst
    rx_avail = 100;
    do_reset(1);
    for (int c = 0; c < 30 && rx_cnt < 3; c++) begin
      rxf_b = (rx_avail == 0);
      cycle();
    end
    check("t40_mid_reads", rx_cnt, 3);
    reset_b = 1'b0;
    cycle();
    reset_b = 1'b1;
    rxf_b = 1'b1; rx_avail = 0;
    repeat (4) cycle();

    // random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      tx_valid = ($urandom_range(0, 3) != 0);
      txe_b    = ($urandom_range(0, 4) == 0);
      rx_en    = ($urandom_range(0, 3) != 0);
      rxf_b    = ($urandom_range(0, 3) == 0);
      reset_b  = ($urandom_range(0, 299) != 0);
      cycle();
    end
    reset_b = 1'b1;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
